// File: rtl/seq_1010_pkg.sv
// Shared definitions for the 1010 frame transmitter and detector.
package seq_1010_pkg;

  localparam int unsigned SYNC_W = 4;
  localparam logic [SYNC_W-1:0] SYNC_PAT = 4'b1010;

  typedef enum logic [1:0] {IDLE, SYNC, DATA, GAP} state_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register: parallel load, MSB-first shift-out.
module piso_shift_reg #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         msb
);

  logic [W-1:0] data;

  always_ff @(posedge clk) begin
    if (reset) begin
      data <= '0;
    end else if (load) begin
      data <= din;
    end else if (shift) begin
      data <= data << 1;
    end
  end

  assign msb = data[W-1];

endmodule

// File: rtl/seq_frame_tx_1010.sv
// Serial frame transmitter: sync header, MSB-first payload, then a zero gap.
module seq_frame_tx_1010 #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned GAP_LEN = 2,
  parameter logic [3:0]  SYNC_PAT = seq_1010_pkg::SYNC_PAT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_bit,
  output logic              out_valid,
  output logic              sync_active,
  output logic              frame_done
);
  import seq_1010_pkg::*;

  localparam int unsigned CNT_W = $clog2(max3(SYNC_W, DATA_W, GAP_LEN) + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO  = CNT_W'(2);
  localparam logic [CNT_W-1:0] CNT_SYNC = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_LEN);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [SYNC_W-1:0] hdr;
  logic              msb;
  logic              last_c;
  logic              load_c;
  logic              shift_c;

  // Payload advances on the header's last bit and on every payload bit but the last.
  always_comb begin
    last_c  = (cnt == CNT_ONE);
    load_c  = (state == IDLE) && in_valid && in_ready;
    shift_c = ((state == SYNC) && last_c) || ((state == DATA) && !last_c);
  end

  piso_shift_reg #(.W(DATA_W)) u_payload (
    .clk   (clk),
    .reset (reset),
    .load  (load_c),
    .shift (shift_c),
    .din   (in_data),
    .msb   (msb)
  );

  // Outputs are registered alongside the state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      hdr         <= '0;
      in_ready    <= 1'b1;
      out_bit     <= 1'b0;
      out_valid   <= 1'b0;
      sync_active <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            state       <= SYNC;
            cnt         <= CNT_SYNC;
            hdr         <= SYNC_PAT << 1;
            out_bit     <= SYNC_PAT[SYNC_W-1];
            out_valid   <= 1'b1;
            sync_active <= 1'b1;
            in_ready    <= 1'b0;
          end
        end
        SYNC: begin
          if (last_c) begin
            state       <= DATA;
            cnt         <= CNT_DATA;
            out_bit     <= msb;
            sync_active <= 1'b0;
            frame_done  <= (DATA_W == 1);
          end else begin
            cnt     <= cnt - CNT_ONE;
            out_bit <= hdr[SYNC_W-1];
            hdr     <= hdr << 1;
          end
        end
        DATA: begin
          if (last_c) begin
            out_bit   <= 1'b0;
            out_valid <= 1'b0;
            if (GAP_LEN == 0) begin
              state    <= IDLE;
              in_ready <= 1'b1;
            end else begin
              state <= GAP;
              cnt   <= CNT_GAP;
            end
          end else begin
            cnt        <= cnt - CNT_ONE;
            out_bit    <= msb;
            frame_done <= (cnt == CNT_TWO);
          end
        end
        GAP: begin
          if (last_c) begin
            state    <= IDLE;
            in_ready <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_frame_tx_1010.sv
// Directed bench for seq_frame_tx_1010: default and short/no-gap configurations.
module tb_seq_frame_tx_1010;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default configuration: DATA_W=8, GAP_LEN=2
  logic       ra, va;
  logic [7:0] da;
  logic       rdy_a, bit_a, vld_a, syn_a, fd_a;

  // Short configuration: DATA_W=4, GAP_LEN=0
  logic       rb, vb;
  logic [3:0] db;
  logic       rdy_b, bit_b, vld_b, syn_b, fd_b;

  seq_frame_tx_1010 u_a (
    .clk(clk), .reset(ra), .in_valid(va), .in_data(da), .in_ready(rdy_a),
    .out_bit(bit_a), .out_valid(vld_a), .sync_active(syn_a), .frame_done(fd_a)
  );

  seq_frame_tx_1010 #(.DATA_W(4), .GAP_LEN(0)) u_b (
    .clk(clk), .reset(rb), .in_valid(vb), .in_data(db), .in_ready(rdy_b),
    .out_bit(bit_b), .out_valid(vld_b), .sync_active(syn_b), .frame_done(fd_b)
  );

  typedef struct {
    logic       in_valid;
    logic [7:0] in_data;
    logic [4:0] exp;   // {out_bit, out_valid, sync_active, frame_done, in_ready}
  } vec_t;

  vec_t vecs[16];
  int   tests  = 0;
  int   failed = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] outs_a();
    return {bit_a, vld_a, syn_a, fd_a, rdy_a};
  endfunction

  initial begin
    logic [7:0] s2;
    logic [3:0] win;
    int hits, hdrs, data_ones;
    int t[3];
    logic prev_syn;
    bit fd_seen;

    ra = 1'b1; va = 1'b0; da = '0;
    rb = 1'b1; vb = 1'b0; db = '0;
    step();
    chk("reset_a", 32'(outs_a()), 32'(5'b00001));
    chk("reset_b", 32'({bit_b, vld_b, syn_b, fd_b, rdy_b}), 32'(5'b00001));
    ra = 1'b0; rb = 1'b0;
    step();
    chk("idle_a", 32'(outs_a()), 32'(5'b00001));

    // A5 frame, with payload changes and in_valid pulses outside IDLE
    vecs[0]  = '{1'b1, 8'hA5, 5'b11100};
    vecs[1]  = '{1'b0, 8'h00, 5'b01100};
    vecs[2]  = '{1'b0, 8'h00, 5'b11100};
    vecs[3]  = '{1'b0, 8'h00, 5'b01100};
    vecs[4]  = '{1'b0, 8'h00, 5'b11000};
    vecs[5]  = '{1'b1, 8'h5A, 5'b01000};
    vecs[6]  = '{1'b0, 8'h5A, 5'b11000};
    vecs[7]  = '{1'b0, 8'h00, 5'b01000};
    vecs[8]  = '{1'b0, 8'h00, 5'b01000};
    vecs[9]  = '{1'b0, 8'h00, 5'b11000};
    vecs[10] = '{1'b1, 8'hFF, 5'b01000};
    vecs[11] = '{1'b0, 8'h00, 5'b11010};
    vecs[12] = '{1'b0, 8'h00, 5'b00000};
    vecs[13] = '{1'b1, 8'h3C, 5'b00000};
    vecs[14] = '{1'b0, 8'h00, 5'b00001};
    vecs[15] = '{1'b0, 8'h00, 5'b00001};
    for (int i = 0; i < 16; i++) begin
      va = vecs[i].in_valid;
      da = vecs[i].in_data;
      step();
      chk($sformatf("vec%0d", i), 32'(outs_a()), 32'(vecs[i].exp));
    end
    va = 1'b0;

    // Short frame without gap: 1010 then 0011, ready right after the last bit
    s2 = 8'b1010_0011;
    vb = 1'b1; db = 4'h3;
    step();
    vb = 1'b0; db = 4'hC;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b_bit%0d", i), 32'({bit_b, vld_b, fd_b}), 32'({s2[7-i], 1'b1, (i == 7)}));
      step();
    end
    chk("b_ready_after", 32'({rdy_b, vld_b, bit_b}), 32'(3'b100));

    // Reset during the third payload bit aborts the frame
    va = 1'b1; da = 8'hA5;
    step();
    va = 1'b0;
    fd_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      fd_seen |= fd_a;
      step();
    end
    fd_seen |= fd_a;
    chk("abort_pre", 32'({bit_a, vld_a, syn_a}), 32'(3'b110));
    ra = 1'b1;
    step();
    ra = 1'b0;
    chk("abort_post", 32'(outs_a()), 32'(5'b00001));
    for (int i = 0; i < 8; i++) begin
      fd_seen |= fd_a | vld_a;
      step();
    end
    chk("abort_no_done", 32'(fd_seen), 32'(0));

    // Reset and in_valid together: no accept
    ra = 1'b1; va = 1'b1; da = 8'hFF;
    step();
    chk("rst_vs_valid", 32'(outs_a()), 32'(5'b00001));
    ra = 1'b0; va = 1'b0;
    step();
    chk("rst_vs_valid_after", 32'(outs_a()), 32'(5'b00001));

    // Back-to-back FF, 00, 00 with a 1010 detector watching the line
    win = '0; hits = 0; hdrs = 0; data_ones = 0; prev_syn = 1'b0;
    t[0] = -1; t[1] = -1; t[2] = -1;
    va = 1'b1; da = 8'hFF;
    for (int c = 0; c < 45; c++) begin
      step();
      da = 8'h00;
      win = {win[2:0], bit_a};
      if (win == 4'b1010) begin
        hits++;
        chk($sformatf("hit_align_c%0d", c), 32'({syn_a, vld_a}), 32'(2'b11));
      end
      if (syn_a && !prev_syn) begin
        if (hdrs < 3) t[hdrs] = c;
        hdrs++;
      end
      prev_syn = syn_a;
      if (vld_a && !syn_a && bit_a) data_ones++;
    end
    va = 1'b0;
    chk("b2b_headers", 32'(hdrs), 32'(3));
    chk("b2b_period1", 32'(t[1] - t[0]), 32'(15));
    chk("b2b_period2", 32'(t[2] - t[1]), 32'(15));
    chk("loop_hits", 32'(hits), 32'(3));
    chk("payload_ones", 32'(data_ones), 32'(8));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/seq_frame_tx_1010.md
# seq_frame_tx_1010

Serial frame transmitter that produces the bit stream consumed by the 1010 sequence detector. It accepts a parallel payload over a valid/ready handshake and emits one bit per clock: the 4-bit sync header 1010, then the payload MSB-first, then a fixed idle gap of zeros. It sits upstream of the detector's serial input, in the datapath and in the loopback bench.

## Interface
- DATA_W, 8: payload width in bits; legal range 1–32.
- GAP_LEN, 2: number of forced-zero gap cycles after the payload; 0 is legal.
- SYNC_PAT, 4'b1010: sync header, transmitted MSB-first; fixed width 4.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset; one clock; polarity and synchronicity fixed.
- in_valid  input  1  payload offered.
- in_data  input  DATA_W  payload; sampled only on the accept edge.
- in_ready  output  1  block can accept a payload.
- out_bit  output  1  serial line; 0 whenever no frame bit is being driven.
- out_valid  output  1  out_bit carries a sync or payload bit.
- sync_active  output  1  out_bit is a header bit.
- frame_done  output  1  one-cycle pulse, high during the last payload bit.

## Operation
- FSM states and outputs:
  - IDLE: in_ready=1; out_bit=0; out_valid=0.
  - SYNC: 4 cycles.
  - DATA: DATA_W cycles.
  - GAP: GAP_LEN cycles; out_bit=0; out_valid=0; in_ready=0.
- Transitions:
  - Accept is in_valid && in_ready, which is only possible in IDLE. On accept, in_data loads into the payload shift register and the FSM goes to SYNC.
  - SYNC emits SYNC_PAT[3], [2], [1], [0] on successive cycles, then goes to DATA.
  - DATA emits in_data[DATA_W-1] down to in_data[0], then goes to GAP. If GAP_LEN=0 it goes directly to IDLE.
  - GAP counts GAP_LEN cycles, then goes to IDLE.
- One down-counter is shared across SYNC, DATA and GAP.
  - It is reloaded on each state entry.
  - Width is $clog2(max(4, DATA_W, GAP_LEN)+1).
  - It never wraps: the state exit fires when count==1.
- in_valid and in_data are ignored outside IDLE. A payload held across a frame is accepted on the first IDLE cycle.
- The payload is not bit-stuffed. A payload containing 1010 (or overlapping the header's tail) causes extra detector hits. This is a documented non-goal.
- All outputs are registered; no combinational path runs from inputs to outputs.
- Reset values: in_ready=1, out_bit=0, out_valid=0, sync_active=0, frame_done=0, state=IDLE.
- Reset mid-frame:
  - The frame is aborted and the payload discarded.
  - frame_done does not pulse.
  - Outputs are at reset values on the cycle after the reset edge.
- Reset and in_valid in the same cycle: reset wins and no accept occurs.

## Timing
- Accept edge at cycle N: first header bit on out_bit in cycle N+1.
- Header occupies N+1..N+4. Payload occupies N+5..N+4+DATA_W.
- frame_done is high in cycle N+4+DATA_W only.
- Gap occupies the next GAP_LEN cycles. IDLE (in_ready=1) begins at cycle N+5+DATA_W+GAP_LEN.
- Back-to-back frame period is 5+DATA_W+GAP_LEN cycles. With the defaults this is 15 cycles: 12 valid bits, 2 gap cycles, 1 IDLE cycle.
- sync_active equals out_valid && (state==SYNC), aligned with out_bit.

## Structure
- Shared package `seq_1010_pkg`:
  - state enum {IDLE, SYNC, DATA, GAP}.
  - SYNC_PAT constant and SYNC_W=4.
  - The detector imports the same constant.
- Sub-module `piso_shift_reg #(W)`: parallel load, MSB-first shift-out with a shift enable.
  - It is used for the payload.
  - The header is shifted from a 4-bit copy in the parent.

## Test plan
- Defaults, reset then in_valid=1 with in_data=8'hA5:
  - out_bit from N+1 is 1,0,1,0,1,0,1,0,0,1,0,1, then 0,0.
  - out_valid is high for exactly 12 cycles.
  - frame_done is high only on the 12th bit.
  - in_ready returns at N+15.
- in_valid held high with payloads 8'hFF then 8'h00: second frame's first header bit appears exactly 15 cycles after the first frame's.
- GAP_LEN=0, DATA_W=4, in_data=4'h3: stream 1,0,1,0,0,0,1,1; in_ready=1 on the cycle immediately after the last bit.
- Reset asserted at the third payload bit: on the next cycle out_valid=0, out_bit=0 and in_ready=1; no frame_done pulse.
- Loopback into the 1010 detector with in_data=8'h00: exactly one detector hit per frame, aligned to the header's final 0.
- in_data changed during SYNC/DATA: the transmitted payload is unchanged; in_valid pulsed outside IDLE produces no accept.
